// File: rtl/ysyx_23060303_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060303_seq_pkg
//  Brief    : Shared state encodings and halt-code constants for the NPC
//             instruction sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060303_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_e;

  localparam logic [1:0] HC_EBREAK  = 2'd0;
  localparam logic [1:0] HC_ILLEGAL = 2'd1;
  localparam logic [1:0] HC_BUSERR  = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060303_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060303_wait_timer
//  Brief    : Saturating wait counter. Flags expiry when the count reaches
//             TIMEOUT_CYCLES-1; TIMEOUT_CYCLES == 0 disables expiry.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060303_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Clear has priority; counting stops at all-ones so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      localparam logic [TMR_W-1:0] c_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
      assign expired_o = (cnt_q == c_LIMIT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ysyx_23060303_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060303_inst_sequencer
//  Brief    : Multi-cycle control FSM for the NPC core. Sequences FETCH,
//             DECODE, EXEC/MEM and WB for one instruction at a time and
//             halts on ebreak, illegal opcode, bus error or wait timeout.
//             Optional macro YSYX_23060303_SEQ_PERF_EN adds 64-bit cycle and
//             retired-instruction counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060303_inst_sequencer
  import ysyx_23060303_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic        ifu_err,
  input  logic [31:0] ifu_inst,
  output logic [31:0] inst_q,
  input  logic        dec_rd_en,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req,
  output logic        lsu_wr,
  input  logic        lsu_done,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic [1:0]  halt_code,
`ifdef YSYX_23060303_SEQ_PERF_EN
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret,
`endif
  output logic [2:0]  state_o
);

  seq_state_e  state_q,     state_d;
  logic [31:0] instr_q,     instr_d;
  logic [1:0]  halt_code_q, halt_code_d;
  logic        is_store_q,  is_store_d;
  logic        rd_en_q,     rd_en_d;
  logic        w_expired;
  logic        w_clear;
  logic        w_cnt_en;

  // Wait counter restarts on every state change and runs only while waiting.
  assign w_clear  = (state_d != state_q);
  assign w_cnt_en = (state_q == S_FETCH) || (state_q == S_MEM);

  ysyx_23060303_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_clear),
    .cnt_en_i  (w_cnt_en),
    .expired_o (w_expired)
  );

  // Next-state logic; decoder flags are captured in DECODE so later Moore
  // outputs depend on registered data only.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    halt_code_d = halt_code_q;
    is_store_d  = is_store_q;
    rd_en_d     = rd_en_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_err) begin
          state_d     = S_HALT;
          halt_code_d = HC_BUSERR;
        end else if (ifu_valid) begin
          instr_d = ifu_inst;
          state_d = S_DECODE;
        end else if (w_expired) begin
          state_d     = S_HALT;
          halt_code_d = HC_TIMEOUT;
        end
      end
      S_DECODE: begin
        is_store_d = dec_is_store;
        rd_en_d    = dec_rd_en;
        if (dec_illegal) begin
          state_d     = S_HALT;
          halt_code_d = HC_ILLEGAL;
        end else if (dec_is_ebreak) begin
          state_d     = S_HALT;
          halt_code_d = HC_EBREAK;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_MEM: begin
        if (lsu_done) begin
          state_d = S_WB;
        end else if (w_expired) begin
          state_d     = S_HALT;
          halt_code_d = HC_TIMEOUT;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      halt_code_q <= HC_EBREAK;
      is_store_q  <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      halt_code_q <= halt_code_d;
      is_store_q  <= is_store_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign ifu_req   = (state_q == S_FETCH);
  assign lsu_req   = (state_q == S_MEM);
  assign lsu_wr    = (state_q == S_MEM) && is_store_q;
  assign pc_we     = (state_q == S_WB);
  assign rf_we     = (state_q == S_WB) && rd_en_q && !is_store_q;
  assign halt      = (state_q == S_HALT);
  assign halt_code = halt_code_q;
  assign inst_q    = instr_q;
  assign state_o   = state_q;

`ifdef YSYX_23060303_SEQ_PERF_EN
  logic [63:0] perf_cycle_q;
  logic [63:0] perf_instret_q;

  // Active-cycle and retired-instruction counters; frozen in IDLE and HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
        perf_cycle_q <= perf_cycle_q + 64'd1;
      end
      if (state_q == S_WB) begin
        perf_instret_q <= perf_instret_q + 64'd1;
      end
    end
  end

  assign perf_cycle   = perf_cycle_q;
  assign perf_instret = perf_instret_q;
`endif

endmodule
`default_nettype wire
